// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver.
// The receiver takes the slave view; the driver of rx and byte consumer take the master view.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;

    modport master (output rx, input data, input rcv, input ferr, input busy);
    modport slave  (input rx, output data, output rcv, output ferr, output busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: double-flop synchroniser, mid-bit sampling FSM,
// parallel byte output with one-cycle rcv / ferr strobes.
module uart_rx #(
    parameter int BAUDRATE = 104  // bit period in clk cycles; 104 is 115200 baud at 12 MHz
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int CW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
    localparam logic [CW-1:0] HALF = CW'(BAUDRATE / 2);
    localparam logic [CW-1:0] FULL = CW'(BAUDRATE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        WAITHI = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic            rx_meta_r, rxs_r;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [2:0]      bit_r, bit_s;
    logic [7:0]      shift_r, shift_s;
    logic [7:0]      data_r, data_s;
    logic            rcv_r, rcv_s;
    logic            ferr_r, ferr_s;
    logic            busy_r;

    // Next-state, counter, shifter and strobe decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        bit_s   = bit_r;
        shift_s = shift_r;
        data_s  = data_r;
        rcv_s   = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {CW{1'b0}};
                bit_s = 3'd0;
                if (!rxs_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF) begin
                    cnt_s = {CW{1'b0}};
                    if (!rxs_r) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;  // start bit gone by mid-bit: glitch
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == FULL) begin
                    cnt_s   = {CW{1'b0}};
                    shift_s = {rxs_r, shift_r[7:1]};
                    bit_s   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (cnt_r == FULL) begin
                    cnt_s = {CW{1'b0}};
                    if (rxs_r) begin
                        data_s  = shift_r;
                        rcv_s   = 1'b1;
                        state_s = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = WAITHI;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAITHI: begin
                cnt_s = {CW{1'b0}};
                if (rxs_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAITHI;
                end
            end
            default: begin
                cnt_s   = {CW{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // Synchroniser, FSM state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_r     <= 3'd0;
            shift_r   <= 8'h00;
            data_r    <= 8'h00;
            rcv_r     <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            rx_meta_r <= bus.rx;
            rxs_r     <= rx_meta_r;
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_r     <= bit_s;
            shift_r   <= shift_s;
            data_r    <= data_s;
            rcv_r     <= rcv_s;
            ferr_r    <= ferr_s;
            busy_r    <= (state_s != IDLE);
        end
    end

    assign bus.data = data_r;
    assign bus.rcv  = rcv_r;
    assign bus.ferr = ferr_r;
    assign bus.busy = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 cycles/bit: serialiser drives rx,
// expected bytes are queued at drive time and popped on every rcv strobe.
module tb_uart_rx;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_if bus ();

    uart_rx #(.BAUDRATE(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         rcv_times[$];
    int         rcv_count = 0;
    int         ferr_count = 0;
    int         busy_cnt = 0;
    int         unexpected = 0;
    int         last_fall = 0;
    int         r0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) exp_q.push_back(b);
        bus.rx = 1'b0;
        last_fall = cyc;
        tick(D);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(D);
        end
        bus.rx = stop;
        tick(D);
    endtask

    // Output monitor: strobe bookkeeping and scoreboard pop.
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.ferr === 1'b1) ferr_count++;
        if (bus.rcv === 1'b1) begin
            rcv_count++;
            rcv_times.push_back(cyc);
            check_eq("rcv_ferr_excl", 32'({bus.rcv, bus.ferr}), 32'd2);
            if (exp_q.size() > 0) begin
                check_eq("rx_data", 32'(bus.data), 32'(exp_q.pop_front()));
            end else begin
                unexpected++;
            end
        end
    end

    initial begin
        logic [7:0] b;
        bus.rx = 1'b1;
        rst = 1'b1;
        tick(3);
        check_eq("rst_data", 32'(bus.data), 32'h00);
        check_eq("rst_rcv",  32'(bus.rcv),  32'd0);
        check_eq("rst_ferr", 32'(bus.ferr), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick(50);
        check_eq("idle_rcv",  32'(rcv_count),  32'd0);
        check_eq("idle_ferr", 32'(ferr_count), 32'd0);
        check_eq("idle_busy", 32'(busy_cnt),   32'd0);

        // single frame: rcv lands 2 sync cycles + 154 cycles after the rx fall
        busy_cnt = 0;
        rcv_times.delete();
        send_frame(8'h55, 1'b1);
        tick(4);
        check_eq("one_rcv_count", 32'(rcv_count), 32'd1);
        check_eq("one_data", 32'(bus.data), 32'h55);
        check_eq("one_busy_len", 32'(busy_cnt), 32'd153);
        if (rcv_times.size() > 0) begin
            check_eq("one_rcv_lat", 32'(rcv_times[0] - last_fall), 32'd156);
        end else begin
            check_eq("one_rcv_seen", 32'(rcv_times.size()), 32'd1);
        end

        // glitch shorter than half a bit
        busy_cnt = 0;
        r0 = rcv_count;
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        tick(30);
        check_eq("glitch_busy_len", 32'(busy_cnt), 32'd9);
        check_eq("glitch_rcv", 32'(rcv_count - r0), 32'd0);
        check_eq("glitch_ferr", 32'(ferr_count), 32'd0);
        check_eq("glitch_data", 32'(bus.data), 32'h55);

        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b1);
        tick(2);
        check_eq("fe_pre_data", 32'(bus.data), 32'h3C);
        send_frame(8'hA3, 1'b0);
        tick(40);
        check_eq("fe_busy_low_line", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        tick(2);
        check_eq("fe_busy_hold", 32'(bus.busy), 32'd1);
        tick(1);
        check_eq("fe_busy_release", 32'(bus.busy), 32'd0);
        check_eq("fe_ferr_count", 32'(ferr_count), 32'd1);
        check_eq("fe_data_kept", 32'(bus.data), 32'h3C);
        send_frame(8'h7E, 1'b1);
        tick(4);
        check_eq("fe_next_data", 32'(bus.data), 32'h7E);

        // back-to-back frames with no idle bits
        rcv_times.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        tick(4);
        check_eq("b2b_count", 32'(rcv_times.size()), 32'd3);
        if (rcv_times.size() == 3) begin
            check_eq("b2b_gap1", 32'(rcv_times[1] - rcv_times[0]), 32'd160);
            check_eq("b2b_gap2", 32'(rcv_times[2] - rcv_times[1]), 32'd160);
        end
        check_eq("b2b_data", 32'(bus.data), 32'h81);

        // reset in the middle of data bit 4
        r0 = rcv_count;
        b = 8'hC6;
        bus.rx = 1'b0;
        tick(D);
        for (int i = 0; i < 4; i++) begin
            bus.rx = b[i];
            tick(D);
        end
        bus.rx = b[4];
        tick(D / 2);
        rst = 1'b1;
        tick(3);
        check_eq("mid_rst_data", 32'(bus.data), 32'h00);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.rx = 1'b1;
        tick(40);
        check_eq("mid_rst_rcv", 32'(rcv_count - r0), 32'd0);
        check_eq("mid_rst_ferr", 32'(ferr_count), 32'd1);
        check_eq("mid_rst_data_after", 32'(bus.data), 32'h00);
        send_frame(8'h12, 1'b1);
        tick(4);
        check_eq("post_rst_data", 32'(bus.data), 32'h12);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("unexpected_rcv", 32'(unexpected), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of the team's `uart_tx`. It deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from an asynchronous `rx` line. Each byte is presented on a parallel output with a one-cycle strobe. It sits between the board RX pin (e.g. the ICEstick FTDI link) and any byte consumer in the design.

## Interface
- `BAUDRATE`, default `` `B115200 `` (from `baudgen.vh`): bit period in `clk` cycles (D); legal range D ≥ 8.
- `clk`  input  1  system clock (12 MHz on ICEstick).
- `rst`  input  1  reset; synchronous and active-high.
- `rx`  input  1  serial line, asynchronous to `clk`; idles high.
- `data`  output  8  last correctly received byte; held until the next good frame.
- `rcv`  output  1  one-cycle pulse: `data` has just been updated.
- `ferr`  output  1  one-cycle pulse: framing error (stop bit sampled 0).
- `busy`  output  1  high while a frame is in progress or the receiver waits for the line to return high.

## Operation
- Input synchroniser: `rx` passes through two flops, both reset to 1. All logic below uses the synchronised signal `rxs`.
- Internal baud counter: counts 0..D-1 and is cleared on every state entry. A sample tick occurs when the counter reaches the target: H = D/2 (integer division) in START, D-1 in DATA and STOP.
- Bit counter: 3 bits, counts data bits 0..7.
- Shift register: 8 bits, shifts right with `rxs` entering at bit 7, so the first received bit ends up as the LSB.
- FSM states: IDLE, START, DATA, STOP, WAITHI.
  - IDLE: `busy`=0. If `rxs`==0, go to START.
  - START: at the H tick, if `rxs`==0 go to DATA; otherwise treat it as a glitch and return to IDLE with no output.
  - DATA: at each tick, shift in `rxs`. After the 8th bit, go to STOP.
  - STOP: at the tick, sample `rxs`.
    - If 1: load `data` from the shift register, pulse `rcv`, go to IDLE.
    - If 0: pulse `ferr`, leave `data` unchanged, go to WAITHI.
  - WAITHI: stay until `rxs`==1, then go to IDLE. This also covers a break condition.
- `busy` = (state != IDLE).
- `rst` has priority over everything and works at any point mid-frame:
  - state → IDLE; counters → 0; shift register → 0.
  - `data`=0x00, `rcv`=0, `ferr`=0, `busy`=0; synchroniser flops = 1.
  - The partial frame is discarded with no strobe.

## Timing
- Let t0 be the first cycle in which `rxs`==0 while in IDLE. `rx` falling edge to `rxs` is 2 cycles.
- Start validation sample: t0+1+H.
- Data bit i (i = 0..7) sampled at t0+1+H+(i+1)·D. Stop bit sampled at t0+1+H+9·D.
- `rcv`/`ferr` are registered: high for exactly the one cycle following the stop sample. `data` is valid in that same cycle and held afterwards.
- `busy` falls in the same cycle `rcv` rises. The FSM is in IDLE that cycle and detects a new start bit in the next cycle, so back-to-back frames with zero idle time are received without loss. This holds because the stop sample is at mid-bit, leaving about D/2 margin.
- `rcv` and `ferr` are never high in the same cycle.
- Throughput: one byte per 10·D cycles, maximum.
- Tolerated baud mismatch: ±4 % with D ≥ 16.

## Test plan
Use D=16 in simulation; drive `rx` with a bench serialiser at exactly 16 cycles/bit.
- Reset: hold `rst`=1 for 3 cycles, `rx`=1 → `data`=0x00, `rcv`=`ferr`=`busy`=0; release, then idle 50 cycles → no strobes.
- Single frame 0x55 → exactly one `rcv` pulse, `data`=0x55, `busy` high for 153 cycles. Check the `rcv` cycle against the formula: 1+8+9·16+1 cycles after t0.
- Glitch: `rx` low for 4 cycles, then high → `busy` high for 9 cycles, then 0; no `rcv`/`ferr`; `data` unchanged.
- Framing error: after a good 0x3C, send 0xA3 with stop bit 0, then hold `rx` low 40 cycles before releasing → single `ferr` pulse, `data` stays 0x3C, `busy` stays high until 2 cycles after `rx` goes high, then a following 0x7E frame is received correctly.
- Back-to-back: 0x00, 0xFF, 0x81 with zero idle bits → three `rcv` pulses, 160 cycles apart, with `data` = 0x00, 0xFF, 0x81 respectively.
- Reset mid-frame: assert `rst` during data bit 4 of 0xC6 → no strobe, `data`=0x00; after release and line idle, the next frame 0x12 gives `data`=0x12.
